// File: rtl/fetch_pkg.sv
// Shared state encoding, defaults and widths for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] DEF_RESET_PC   = 16'h0000;
  localparam logic [3:0]         DEF_HLT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  // Instructions are halfword aligned, so redirect targets drop bit 0.
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
    return {pc[INSTR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/add_sub_16.sv
// 16-bit adder/subtractor with signed-overflow flag; results wrap mod 2^16.
module add_sub_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        Ovfl
);

  logic [15:0] b_eff;

  assign b_eff = b ^ {16{sub}};
  assign sum   = a + b_eff + {15'b0, sub};
  assign Ovfl  = (a[15] == b_eff[15]) && (sum[15] != a[15]);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding request, single-entry output buffer.
// Optional perf counters (fetch_cnt, squash_cnt) enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [3:0]         HLT_OPCODE = DEF_HLT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_pc,
  output logic [INSTR_W-1:0] if_pc_plus2,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        squash_cnt,
`endif
  output logic               halted
);

  fetch_state_e       state, state_nxt;
  logic [INSTR_W-1:0] pc, pc_nxt, pc_plus2, redirect_aligned;
  logic               squash, squash_nxt;
  logic               load_buf, drop;
  logic               pc_ovfl_unused;

  assign redirect_aligned = align_pc(redirect_pc);

  add_sub_16 u_pc_inc (
    .a    (pc),
    .b    (16'd2),
    .sub  (1'b0),
    .sum  (pc_plus2),
    .Ovfl (pc_ovfl_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ISSUE;
      pc     <= RESET_PC;
      squash <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      squash <= squash_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    squash_nxt = squash;
    load_buf   = 1'b0;
    drop       = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc;
    if_valid   = 1'b0;
    halted     = 1'b0;
    case (state)
      ISSUE: begin
        // Reset shares the ISSUE encoding, so mask the request while rst is held.
        imem_req  = !rst;
        state_nxt = WAIT;
        if (redirect) begin
          imem_addr = redirect_aligned;
          pc_nxt    = redirect_aligned;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt     = redirect_aligned;
          squash_nxt = 1'b1;
        end
        if (imem_valid) begin
          if (squash || redirect) begin
            squash_nxt = 1'b0;
            drop       = 1'b1;
            state_nxt  = ISSUE;
          end else begin
            load_buf  = 1'b1;
            pc_nxt    = pc_plus2;
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if_valid = 1'b1;
        if (redirect) begin
          pc_nxt    = redirect_aligned;
          drop      = 1'b1;
          state_nxt = ISSUE;
        end else if (if_ready) begin
          state_nxt = (if_instr[15:12] == HLT_OPCODE) ? HALT : ISSUE;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus2 <= '0;
    end else if (load_buf) begin
      if_instr    <= imem_data;
      if_pc       <= pc;
      if_pc_plus2 <= pc_plus2;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (load_buf) fetch_cnt  <= fetch_cnt + 16'd1;
      if (drop)     squash_cnt <= squash_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of decode/execute. Holds the architectural PC, issues one request at a time to a variable-latency instruction memory, and buffers the returned instruction with its PC and PC+2 behind a valid/ready handshake. Accepts branch/jump redirects from the downstream stage and squashes wrong-path fetches. Stops fetching once a HLT instruction has been handed downstream.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `HLT_OPCODE`, default 4'hF: value of `instr[15:12]` that marks a halt.

- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `imem_req`, out, 1: single-cycle request pulse.
- `imem_addr`, out, 16: fetch address; valid only while `imem_req`=1.
- `imem_data`, in, 16: instruction word; valid only while `imem_valid`=1.
- `imem_valid`, in, 1: response strobe; arrives 1 or more cycles after `imem_req`.
- `redirect`, in, 1: downstream requests a PC change; sampled every cycle.
- `redirect_pc`, in, 16: new PC; bit 0 is forced to 0.
- `if_valid`, out, 1: output buffer holds an instruction.
- `if_ready`, in, 1: downstream accepts the buffer this cycle.
- `if_instr`, out, 16: buffered instruction.
- `if_pc`, out, 16: address of `if_instr`.
- `if_pc_plus2`, out, 16: `if_pc` + 2, mod 2^16.
- `halted`, out, 1: HLT accepted downstream; fetch permanently stopped.

## Operation
- **States**: ISSUE, WAIT, FULL, HALT. A `squash` flag applies in WAIT only.
- **Reset**:
  - state = ISSUE, pc = `RESET_PC`, `squash` = 0.
  - Outputs: `if_valid` 0, `halted` 0, `imem_req` 0 (combinational from state is permitted after reset release), `if_instr`/`if_pc`/`if_pc_plus2` = 0.
- **ISSUE**:
  - Drive `imem_req`=1 and `imem_addr`=pc. If `redirect`=1, `imem_addr`=`redirect_pc` instead (bypass) and pc <= `redirect_pc`.
  - Next state: WAIT.
- **WAIT**:
  - If `redirect`=1: pc <= `redirect_pc`, `squash` <= 1.
  - On `imem_valid` with `squash`=0 and no `redirect` this cycle:
    - Load buffer: `if_instr` <= `imem_data`, `if_pc` <= pc, `if_pc_plus2` <= pc+2.
    - pc <= pc+2. Next state: FULL.
  - On `imem_valid` with `squash`=1 or `redirect`=1: discard the data, clear `squash`, next state ISSUE.
  - A stray `imem_valid` outside WAIT is ignored.
- **FULL**:
  - `if_valid`=1.
  - `redirect`=1 has priority over `if_ready`: drop the buffer (`if_valid` 0 next cycle), pc <= `redirect_pc`, next state ISSUE.
  - Otherwise, if `if_ready`=1: next state is HALT when `if_instr[15:12]`==`HLT_OPCODE`, else ISSUE.
  - Otherwise hold all outputs stable.
- **HALT**:
  - `halted`=1, `imem_req`=0, `if_valid`=0. `redirect` is ignored.
  - Only `rst` exits this state.
- **Arithmetic**: all PC arithmetic is 16-bit and wraps (16'hFFFE + 2 = 16'h0000). Overflow is not reported.

## Timing
- With 1-cycle memory, the first `imem_req` is in cycle 0 after `rst` falls, `imem_valid` in cycle 1, and `if_valid` in cycle 2.
- Steady-state throughput is 1 instruction per (2 + memory latency) cycles when `if_ready` is held high.
- The redirect-to-request penalty is 0 cycles in ISSUE, next-response+1 cycles in WAIT, and 1 cycle in FULL.
- Buffer outputs change only on the load edge or on reset.
- `rst` asserted mid-WAIT: any response arriving later is ignored because state is ISSUE, and the next request goes to `RESET_PC`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds output `fetch_cnt` [15:0], which increments on each buffer load.
  - Adds output `squash_cnt` [15:0], which increments on each discarded response and each FULL-state flush.
  - Both counters wrap, reset to 0, and do not count in HALT.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (ISSUE, WAIT, FULL, HALT, 2 bits);
  - `DEF_RESET_PC` and `DEF_HLT_OPCODE`;
  - `INSTR_W` = 16.
- Sub-module: the existing `add_sub_16` computes pc+2 (`sub`=0; `Ovfl` unused). No other sub-modules.

## Test plan
- Reset release, 1-cycle memory returning 16'hA123, 16'hB456, `if_ready`=1:
  - `imem_addr` is 0x0000 then 0x0002.
  - The bench sees `if_instr`=A123 with `if_pc`=0, `if_pc_plus2`=2, then B456 with `if_pc`=2, 3 cycles apart.
- Backpressure: `if_ready`=0 for 5 cycles in FULL:
  - `if_valid` and the buffer stay stable and no `imem_req` is issued.
  - When `if_ready`=1, the next request goes to `if_pc`+2.
- Redirect in WAIT (3-cycle memory), `redirect_pc`=0x0040:
  - The old response is discarded and the next `imem_req` has address 0x0040.
  - `if_valid` never shows the stale word; `squash_cnt`=1 when `FETCH_PERF_CNT_EN` is defined.
- Redirect with `if_ready`=1 in FULL:
  - The buffer is dropped and the next request goes to the redirect address.
  - `redirect` and `imem_valid` in the same WAIT cycle: the data is discarded.
- HLT 16'hF000 at 0x0004:
  - Delivered with `if_valid`; after the accepting edge, `halted`=1.
  - No further `imem_req` for 20 cycles, and a `redirect` there is ignored.
- Wrap and reset:
  - `RESET_PC`=16'hFFFE: fetch 0xFFFE, then 0x0000.
  - Assert `rst` mid-WAIT: outputs clear asynchronously and fetch restarts at `RESET_PC`.
